slcorem0_rstctrl: RTL and testbench
===================================

Name: slcorem0_rstctrl

Overview:
System reset request controller that sits directly upstream of the SLCore-M0 subsystem's SYS_SYSRESETREQ input. It collects reset requests from the core (SYSRESETREQ, filtered LOCKUP), the PRMU and the watchdog. It issues one stretched system reset request per event and waits for the generated system reset to complete. It also keeps a sticky reset-cause record that survives system reset, because it is reset only by power-on reset.

Parameters:
PULSE_LEN, 4, minimum cycles SYS_SYSRESETREQ stays high (1..255)
WAIT_TIMEOUT, 16, max cycles in WAIT for SYS_HRESETn low before forced recovery (1..255)
HOLDOFF, 8, consecutive cycles SYS_HRESETn must be high before re-arming (1..255)
LOCKUP_DELAY, 16, consecutive cycles CORE_LOCKUP must persist before it counts as a request (1..255)

Ports:
SYS_FCLK  input  1  free-running clock; sole clock
SYS_PORESETn  input  1  power-on reset; synchronous, active-low
SYS_HRESETn  input  1  generated system reset, observed as status only (same domain)
CORE_SYSRESETREQ  input  1  core AIRCR reset request, level
CORE_LOCKUP  input  1  core lockup status, level
CORE_PRMURESETREQ  input  1  PRMU reset request, level
WDOG_RESETREQ  input  1  watchdog reset request, level
LOCKUPRSTEN  input  1  system register: lockup may cause reset
RSTINFO_CLR  input  1  single-cycle clear of RSTINFO
SYS_SYSRESETREQ  output  1  registered reset request to the subsystem
RSTCTRL_BUSY  output  1  high when state is not IDLE
RSTINFO  output  5  sticky cause: [0] SYSRESETREQ, [1] WDOG, [2] LOCKUP, [3] PRMU, [4] TIMEOUT

Behaviour:
- Reset: on SYS_PORESETn low at a rising edge, state=IDLE, all counters 0, SYS_SYSRESETREQ=0, RSTCTRL_BUSY=0, RSTINFO=5'b0. SYS_HRESETn does not reset this block.
- Lockup filter: 8-bit counter increments each cycle that CORE_LOCKUP&&LOCKUPRSTEN, saturates at LOCKUP_DELAY, clears to 0 otherwise. lockup_req = (count==LOCKUP_DELAY).
- req_any = CORE_SYSRESETREQ | WDOG_RESETREQ | CORE_PRMURESETREQ | lockup_req.
- Cause capture, any state: each cycle, RSTINFO[i] is set for every active source. Multiple simultaneous sources all set. Set wins over RSTINFO_CLR in the same cycle; otherwise RSTINFO_CLR clears all 5 bits.
- FSM, all outputs registered:
  IDLE: req_any sampled at edge N -> ASSERT. SYS_SYSRESETREQ=1 and BUSY=1 from cycle N+1. Counter loaded.
  ASSERT: SYS_SYSRESETREQ=1 for exactly PULSE_LEN cycles, then -> WAIT. A seen_low flag records any SYS_HRESETn=0 observed during ASSERT.
  WAIT: SYS_SYSRESETREQ stays 1.
    - If seen_low, or SYS_HRESETn=0 this cycle -> RECOVER.
    - Otherwise, after WAIT_TIMEOUT cycles in WAIT, set RSTINFO[4] and -> RECOVER.
  RECOVER: SYS_SYSRESETREQ=0. Counter counts consecutive cycles with SYS_HRESETn=1 and restarts on any low. At HOLDOFF -> IDLE; BUSY drops the following cycle.
- Requests arriving in ASSERT/WAIT/RECOVER update RSTINFO only and never restart or extend the sequence.
- Sources still asserted on return to IDLE start a new sequence. Requests are level-sensitive.
- Minimum request-to-request spacing is PULSE_LEN+1+HOLDOFF+1 cycles.
- Counters are 8 bits and never wrap; each counter saturates at its parameter value.
- A SYS_PORESETn assertion mid-sequence aborts immediately to IDLE with RSTINFO cleared.

Optional Feature:
- Macro: SLCOREM0_RSTCTRL_LOCKUP_RST_EN.
- Defined: lockup filter and RSTINFO[2] behave as above.
- Undefined:
  - Filter logic is not generated.
  - lockup_req is tied 0.
  - RSTINFO[2] is constant 0.
  - CORE_LOCKUP and LOCKUPRSTEN remain ports but are ignored.

Test Plan:
- WDOG_RESETREQ high 1 cycle at edge 10, SYS_HRESETn pulled low on cycles 13-15 (defaults) -> SYS_SYSRESETREQ high cycles 11-14 then WAIT. SYS_HRESETn low was seen in ASSERT, so RECOVER at 16. IDLE after 8 high cycles (cycle 23). RSTINFO=5'b00010.
- CORE_LOCKUP high continuously, LOCKUPRSTEN=1 -> request raised after 16 cycles, RSTINFO[2]=1. Repeat with LOCKUPRSTEN=0 -> no request. Repeat with LOCKUP high for 15 cycles then low -> no request.
- SYS_HRESETn held high throughout after CORE_SYSRESETREQ pulse -> SYS_SYSRESETREQ high 4+16 cycles, RSTINFO=5'b10001, then RECOVER and IDLE.
- CORE_PRMURESETREQ and CORE_SYSRESETREQ together, then WDOG_RESETREQ during WAIT -> exactly one sequence, RSTINFO=5'b01011. RSTINFO_CLR coincident with a new WDOG pulse -> RSTINFO=5'b00010.
- CORE_SYSRESETREQ held high for 40 cycles -> back-to-back sequences separated by a single IDLE cycle.
- SYS_PORESETn asserted during WAIT -> next cycle SYS_SYSRESETREQ=0, BUSY=0, RSTINFO=0.

Source files
------------

// File: rtl/slcorem0_rstctrl_if.sv
// slcorem0_rstctrl_if: request/status bundle around the reset request controller.
// slave  = the controller (consumes requests, drives status).
// master = the surrounding subsystem (drives requests, observes status).
`timescale 1ns/1ps
interface slcorem0_rstctrl_if;
   logic       SYS_HRESETn;
   logic       CORE_SYSRESETREQ;
   logic       CORE_LOCKUP;
   logic       CORE_PRMURESETREQ;
   logic       WDOG_RESETREQ;
   logic       LOCKUPRSTEN;
   logic       RSTINFO_CLR;
   logic       SYS_SYSRESETREQ;
   logic       RSTCTRL_BUSY;
   logic [4:0] RSTINFO;

   modport slave (
      input  SYS_HRESETn, CORE_SYSRESETREQ, CORE_LOCKUP, CORE_PRMURESETREQ,
             WDOG_RESETREQ, LOCKUPRSTEN, RSTINFO_CLR,
      output SYS_SYSRESETREQ, RSTCTRL_BUSY, RSTINFO
   );

   modport master (
      output SYS_HRESETn, CORE_SYSRESETREQ, CORE_LOCKUP, CORE_PRMURESETREQ,
             WDOG_RESETREQ, LOCKUPRSTEN, RSTINFO_CLR,
      input  SYS_SYSRESETREQ, RSTCTRL_BUSY, RSTINFO
   );
endinterface

// File: rtl/slcorem0_rstctrl.sv
// slcorem0_rstctrl: collects core/PRMU/watchdog/lockup reset requests, issues one
// stretched SYS_SYSRESETREQ per event, waits for the system reset to complete and
// keeps a sticky cause record that only power-on reset clears.
// Optional feature macro: SLCOREM0_RSTCTRL_LOCKUP_RST_EN (lockup-driven reset).
`timescale 1ns/1ps
module slcorem0_rstctrl #(
   parameter int unsigned PULSE_LEN    = 4,
   parameter int unsigned WAIT_TIMEOUT = 16,
   parameter int unsigned HOLDOFF      = 8,
   parameter int unsigned LOCKUP_DELAY = 16
) (
   input  logic              SYS_FCLK,
   input  logic              SYS_PORESETn,
   slcorem0_rstctrl_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_WAIT, ST_RECOVER} state_e;

   // Counters run 0..LIMIT-1 inside a state, so they never exceed the parameter.
   localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
   localparam logic [7:0] WAIT_LAST  = 8'(WAIT_TIMEOUT - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       seen_low_q, seen_low_d;
   logic       req_q, req_d;
   logic       busy_q, busy_d;
   logic [4:0] info_q, info_d;
   logic [4:0] info_set;
   logic       timeout_set;
   logic       lockup_req;
   logic       req_any;

`ifdef SLCOREM0_RSTCTRL_LOCKUP_RST_EN
   localparam logic [7:0] LOCKUP_LIMIT = 8'(LOCKUP_DELAY);
   logic [7:0] lock_cnt_q, lock_cnt_d;

   // Lockup filter: count consecutive qualified lockup cycles, saturating at the limit.
   always_comb begin
      lock_cnt_d = '0;
      if (bus.CORE_LOCKUP && bus.LOCKUPRSTEN) begin
         lock_cnt_d = (lock_cnt_q == LOCKUP_LIMIT) ? lock_cnt_q : lock_cnt_q + 8'd1;
      end
   end

   // Lockup filter register.
   always_ff @(posedge SYS_FCLK) begin
      if (!SYS_PORESETn) lock_cnt_q <= '0;
      else               lock_cnt_q <= lock_cnt_d;
   end

   assign lockup_req = (lock_cnt_q == LOCKUP_LIMIT);
`else
   // Lockup inputs stay on the port list but have no effect in this build.
   logic lockup_unused;
   assign lockup_unused = bus.CORE_LOCKUP ^ bus.LOCKUPRSTEN;
   assign lockup_req    = 1'b0;
`endif

   assign req_any = bus.CORE_SYSRESETREQ | bus.WDOG_RESETREQ |
                    bus.CORE_PRMURESETREQ | lockup_req;

   // Cause bits: any set this cycle beats a coincident clear.
   assign info_set = {timeout_set, bus.CORE_PRMURESETREQ, lockup_req,
                      bus.WDOG_RESETREQ, bus.CORE_SYSRESETREQ};
   assign info_d   = (bus.RSTINFO_CLR ? 5'b0 : info_q) | info_set;

   // State register plus registered outputs and sticky cause record.
   always_ff @(posedge SYS_FCLK) begin
      if (!SYS_PORESETn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         seen_low_q <= 1'b0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         info_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         seen_low_q <= seen_low_d;
         req_q      <= req_d;
         busy_q     <= busy_d;
         info_q     <= info_d;
      end
   end

   // Next-state logic: one request sequence, never restarted by later requests.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      seen_low_d  = seen_low_q;
      timeout_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d      = '0;
            seen_low_d = 1'b0;
            if (req_any) state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (!bus.SYS_HRESETn) seen_low_d = 1'b1;
            if (cnt_q >= PULSE_LAST) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_WAIT: begin
            if (seen_low_q || !bus.SYS_HRESETn) begin
               state_d = ST_RECOVER;
               cnt_d   = '0;
            end else if (cnt_q >= WAIT_LAST) begin
               // System reset never showed up: record it and recover anyway.
               timeout_set = 1'b1;
               state_d     = ST_RECOVER;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RECOVER: begin
            // Holdoff needs an unbroken run of high SYS_HRESETn cycles.
            if (!bus.SYS_HRESETn) begin
               cnt_d = '0;
            end else if (cnt_q >= HOLD_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: decoded from the next state so the outputs are registered.
   always_comb begin
      req_d  = (state_d == ST_ASSERT) || (state_d == ST_WAIT);
      busy_d = (state_d != ST_IDLE);
   end

   assign bus.SYS_SYSRESETREQ = req_q;
   assign bus.RSTCTRL_BUSY    = busy_q;
   assign bus.RSTINFO         = info_q;

endmodule

// File: tb/tb_slcorem0_rstctrl.sv
// tb_slcorem0_rstctrl: table-driven request sequences with a scoreboard queue,
// plus hand-written sequences for lockup, back-to-back and mid-sequence POR.
`timescale 1ns/1ps
module tb_slcorem0_rstctrl;

`ifdef SLCOREM0_RSTCTRL_LOCKUP_RST_EN
   localparam int LOCKUP_ON = 1;
`else
   localparam int LOCKUP_ON = 0;
`endif

   logic clk;
   logic poresetn;
   int   n_checks;
   int   n_fail;

   slcorem0_rstctrl_if rif ();

   slcorem0_rstctrl dut (
      .SYS_FCLK     (clk),
      .SYS_PORESETn (poresetn),
      .bus          (rif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      bit         sysreq;
      bit         wdog;
      bit         prmu;
      bit         clr_req;
      bit         pre_clr;
      int         low1_s;
      int         low1_e;
      int         low2_s;
      int         low2_e;
      int         wdog_at;
      int         exp_req;
      int         exp_busy;
      logic [4:0] exp_info;
   } vec_t;

   typedef struct {
      int         lat;
      int         req_cyc;
      int         busy_cyc;
      logic [4:0] info;
   } exp_t;

   vec_t vecs[6];
   exp_t sb_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_quiet();
      rif.CORE_SYSRESETREQ  = 1'b0;
      rif.CORE_PRMURESETREQ = 1'b0;
      rif.WDOG_RESETREQ     = 1'b0;
      rif.CORE_LOCKUP       = 1'b0;
      rif.LOCKUPRSTEN       = 1'b0;
      rif.RSTINFO_CLR       = 1'b0;
      rif.SYS_HRESETn       = 1'b1;
   endtask

   task automatic pre_clear();
      @(negedge clk);
      drive_quiet();
      rif.RSTINFO_CLR = 1'b1;
      @(negedge clk);
      rif.RSTINFO_CLR = 1'b0;
      @(negedge clk);
   endtask

   // Cycle r=0 carries the request; outputs sampled at each negedge before driving.
   task automatic run_vec(input vec_t v);
      exp_t e;
      exp_t got;
      bit   seen_busy;
      bit   done;
      @(negedge clk);
      drive_quiet();
      rif.RSTINFO_CLR = v.pre_clr;
      @(negedge clk);
      rif.RSTINFO_CLR = 1'b0;
      e.lat = 1; e.req_cyc = v.exp_req; e.busy_cyc = v.exp_busy; e.info = v.exp_info;
      sb_q.push_back(e);
      got.lat = -1; got.req_cyc = 0; got.busy_cyc = 0; got.info = '0;
      seen_busy = 1'b0;
      done      = 1'b0;
      for (int r = 0; r < 100 && !done; r++) begin
         @(negedge clk);
         if (rif.SYS_SYSRESETREQ) begin
            got.req_cyc++;
            if (got.lat < 0) got.lat = r;
         end
         if (rif.RSTCTRL_BUSY) begin
            got.busy_cyc++;
            seen_busy = 1'b1;
         end else if (seen_busy) begin
            got.info = rif.RSTINFO;
            done     = 1'b1;
         end
         rif.CORE_SYSRESETREQ  = (r == 0) && v.sysreq;
         rif.CORE_PRMURESETREQ = (r == 0) && v.prmu;
         rif.RSTINFO_CLR       = (r == 0) && v.clr_req;
         rif.WDOG_RESETREQ     = ((r == 0) && v.wdog) || (r == v.wdog_at);
         rif.SYS_HRESETn       = !((r >= v.low1_s && r <= v.low1_e) ||
                                   (r >= v.low2_s && r <= v.low2_e));
      end
      drive_quiet();
      check({v.name, "_done"}, int'(done), 1);
      e = sb_q.pop_front();
      $display("vec %s: lat=%0d req_cycles=%0d busy_cycles=%0d rstinfo=%05b",
               v.name, got.lat, got.req_cyc, got.busy_cyc, got.info);
      check({v.name, "_latency"}, got.lat, e.lat);
      check({v.name, "_req_cycles"}, got.req_cyc, e.req_cyc);
      check({v.name, "_busy_cycles"}, got.busy_cyc, e.busy_cyc);
      check({v.name, "_rstinfo"}, int'(got.info), int'(e.info));
   endtask

   // Holds lockup for hold_len cycles and returns the first cycle SYS_SYSRESETREQ rose.
   task automatic lockup_run(input int hold_len, input bit en, output int first);
      first = -1;
      for (int r = 0; r < 40; r++) begin
         @(negedge clk);
         if (rif.SYS_SYSRESETREQ && first < 0) first = r;
         rif.CORE_LOCKUP = (r < hold_len);
         rif.LOCKUPRSTEN = en;
      end
      drive_quiet();
      for (int k = 0; k < 80 && rif.RSTCTRL_BUSY; k++) @(negedge clk);
      check("lockup_seq_end_idle", int'(rif.RSTCTRL_BUSY), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected $finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int first;
      int rises;
      int rise1;
      int rise2;
      int fall1;
      bit prev;
      n_checks = 0;
      n_fail   = 0;

      //                name                 sys wd pr clr pre l1s l1e l2s l2e wat req busy info
      vecs[0] = '{"wdog_seen_low",       0, 1, 0, 0, 1,  3,  5, -1, -1, -1,  5, 13, 5'b00010};
      vecs[1] = '{"sysreq_timeout",      1, 0, 0, 0, 1, -1, -1, -1, -1, -1, 20, 28, 5'b10001};
      vecs[2] = '{"prmu_sys_wdog_wait",  1, 0, 1, 0, 1,  5,  5, -1, -1,  5,  5, 13, 5'b01011};
      vecs[3] = '{"clr_with_wdog",       0, 1, 0, 1, 0,  3,  5, -1, -1, -1,  5, 13, 5'b00010};
      vecs[4] = '{"prmu_timeout",        0, 0, 1, 0, 1, -1, -1, -1, -1, -1, 20, 28, 5'b11000};
      vecs[5] = '{"recover_restart",     1, 0, 0, 0, 1,  3,  3,  8,  8, 10,  5, 16, 5'b00011};

      // Power-on reset state.
      drive_quiet();
      poresetn = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_sysresetreq", int'(rif.SYS_SYSRESETREQ), 0);
      check("reset_busy", int'(rif.RSTCTRL_BUSY), 0);
      check("reset_rstinfo", int'(rif.RSTINFO), 0);
      poresetn = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset_busy", int'(rif.RSTCTRL_BUSY), 0);
      $display("reset: sysresetreq=%0b busy=%0b rstinfo=%05b",
               rif.SYS_SYSRESETREQ, rif.RSTCTRL_BUSY, rif.RSTINFO);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Lockup held continuously with LOCKUPRSTEN=1.
      pre_clear();
      lockup_run(40, 1'b1, first);
      $display("lockup_held: first_req=%0d rstinfo=%05b", first, rif.RSTINFO);
      check("lockup_held_first_req", first, (LOCKUP_ON != 0) ? 17 : -1);
      check("lockup_held_rstinfo2", int'(rif.RSTINFO[2]), LOCKUP_ON);

      // Lockup held but not enabled.
      pre_clear();
      lockup_run(40, 1'b0, first);
      $display("lockup_disabled: first_req=%0d rstinfo=%05b", first, rif.RSTINFO);
      check("lockup_disabled_first_req", first, -1);
      check("lockup_disabled_rstinfo", int'(rif.RSTINFO), 0);

      // Lockup one cycle short of the filter delay.
      pre_clear();
      lockup_run(15, 1'b1, first);
      $display("lockup_short: first_req=%0d rstinfo=%05b", first, rif.RSTINFO);
      check("lockup_short_first_req", first, -1);
      check("lockup_short_rstinfo", int'(rif.RSTINFO), 0);

      // CORE_SYSRESETREQ held 40 cycles: two sequences with a single idle gap.
      pre_clear();
      rises = 0; rise1 = -1; rise2 = -1; fall1 = -1; prev = 1'b0;
      for (int r = 0; r < 80; r++) begin
         @(negedge clk);
         if (rif.RSTCTRL_BUSY && !prev) begin
            rises++;
            if (rise1 < 0) rise1 = r;
            else if (rise2 < 0) rise2 = r;
         end
         if (!rif.RSTCTRL_BUSY && prev && fall1 < 0) fall1 = r;
         prev = rif.RSTCTRL_BUSY;
         rif.CORE_SYSRESETREQ = (r < 40);
         rif.SYS_HRESETn      = 1'b1;
      end
      drive_quiet();
      $display("back_to_back: rises=%0d rise1=%0d fall1=%0d rise2=%0d", rises, rise1, fall1, rise2);
      check("b2b_sequences", rises, 2);
      check("b2b_rise1", rise1, 1);
      check("b2b_fall1", fall1, 29);
      check("b2b_idle_gap", rise2 - fall1, 1);
      check("b2b_end_idle", int'(rif.RSTCTRL_BUSY), 0);

      // Power-on reset during WAIT aborts and clears the cause record.
      pre_clear();
      for (int r = 0; r < 14; r++) begin
         @(negedge clk);
         if (r == 8) begin
            check("por_pre_sysresetreq", int'(rif.SYS_SYSRESETREQ), 1);
            check("por_pre_rstinfo", int'(rif.RSTINFO), 1);
         end
         if (r == 9) begin
            $display("por_in_wait: sysresetreq=%0b busy=%0b rstinfo=%05b",
                     rif.SYS_SYSRESETREQ, rif.RSTCTRL_BUSY, rif.RSTINFO);
            check("por_sysresetreq", int'(rif.SYS_SYSRESETREQ), 0);
            check("por_busy", int'(rif.RSTCTRL_BUSY), 0);
            check("por_rstinfo", int'(rif.RSTINFO), 0);
         end
         rif.CORE_SYSRESETREQ = (r == 0);
         poresetn             = (r != 8);
      end
      check("por_after_idle", int'(rif.RSTCTRL_BUSY), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
